// File: rtl/ntt_stage_scheduler_pkg.sv
// Shared types and helpers for the NTT stage scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default parameter values, index-width helper.
package ntt_stage_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 18;
  localparam int DEF_LOG_N    = 8;
  localparam int DEF_PIPE_LAT = 2;

  // Width of the butterfly counter and the twiddle index: LOG_N-1 bits,
  // never narrower than one bit so LOG_N=1 still gets a legal vector.
  function automatic int idx_w(input int log_n);
    return (log_n > 1) ? log_n - 1 : 1;
  endfunction

endpackage

// File: rtl/ntt_stage_scheduler_addr_gen.sv
// DIT butterfly address generator: (stage s, butterfly b) -> operand pair and twiddle index.
// Latency: purely combinational.
// Backpressure: none; outputs follow s and b directly.
// Ports: s (stage), b (butterfly within stage) -> addr_1, addr_2 (operand pair), tw (twiddle index).
module ntt_stage_scheduler_addr_gen
  import ntt_stage_scheduler_pkg::*;
#(
  parameter int LOG_N = DEF_LOG_N
) (
  input  logic [LOG_N-1:0]        s,
  input  logic [idx_w(LOG_N)-1:0] b,
  output logic [LOG_N-1:0]        addr_1,
  output logic [LOG_N-1:0]        addr_2,
  output logic [idx_w(LOG_N)-1:0] tw
);

  localparam int BW = idx_w(LOG_N);

  logic [LOG_N-1:0] bx;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] j;
  logic [LOG_N-1:0] k;
  logic [LOG_N-1:0] sh;

  always_comb begin
    bx     = LOG_N'(b);
    half   = LOG_N'(1) << s;
    j      = bx >> s;
    k      = bx & (half - LOG_N'(1));
    // Group j occupies a 2*half block; shifting in two steps avoids a
    // width-limited s+1 wrapping when LOG_N is small.
    addr_1 = ((j << s) << 1) + k;
    addr_2 = addr_1 + half;
    sh     = LOG_N'(LOG_N - 1) - s;
    // k < half, so k << (LOG_N-1-s) always fits in LOG_N-1 bits.
    tw     = BW'(k << sh);
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// In-place radix-2 DIT NTT sequencer: walks LOG_N stages of N/2 butterflies, draining between stages.
// Latency: first rd_en one cycle after start; wr_en trails rd_en by PIPE_LAT non-stalled cycles.
// Backpressure: stall freezes FSM, counters and the write-back delay line; rd_en/wr_en forced low.
// Ports: clk, rst (sync, active-high), start, stall -> busy, done, stage, rd_en, rd_addr_1/2,
//        tw_addr, wr_en, wr_addr_1/2. WIDTH only documents the coefficient width of the datapath.
module ntt_stage_scheduler
  import ntt_stage_scheduler_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOG_N    = DEF_LOG_N,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [LOG_N-1:0]        stage,
  output logic                    rd_en,
  output logic [LOG_N-1:0]        rd_addr_1,
  output logic [LOG_N-1:0]        rd_addr_2,
  output logic [idx_w(LOG_N)-1:0] tw_addr,
  output logic                    wr_en,
  output logic [LOG_N-1:0]        wr_addr_1,
  output logic [LOG_N-1:0]        wr_addr_2
);

  localparam int BW     = idx_w(LOG_N);
  localparam int HALF_N = 2 ** (LOG_N - 1);
  localparam int DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  if (WIDTH < 1 || LOG_N < 1 || PIPE_LAT < 1) begin : g_bad_param
    $error("ntt_stage_scheduler: WIDTH, LOG_N and PIPE_LAT must all be >= 1");
  end

  state_t           state, state_nxt;
  logic [BW-1:0]    b;
  logic [LOG_N-1:0] s;
  logic [DW-1:0]    drain_cnt;
  logic             last_b, last_stage, drain_last;

  logic [LOG_N-1:0] gen_a1, gen_a2;
  logic [BW-1:0]    gen_tw;

  logic             dl_vld [PIPE_LAT];
  logic [LOG_N-1:0] dl_a1  [PIPE_LAT];
  logic [LOG_N-1:0] dl_a2  [PIPE_LAT];

  assign last_b     = (b == BW'(HALF_N - 1));
  assign last_stage = (s == LOG_N'(LOG_N - 1));
  assign drain_last = (drain_cnt == DW'(PIPE_LAT - 1));

  ntt_stage_scheduler_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
    .s      (s),
    .b      (b),
    .addr_1 (gen_a1),
    .addr_2 (gen_a2),
    .tw     (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stall) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = !stall;
        if (!stall && last_b) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!stall && drain_last) state_nxt = last_stage ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!stall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // b saturates at its terminal value during DRAIN and is rewound when the
  // drain completes; s is rewound in DONE so IDLE always reports stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      b         <= '0;
      s         <= '0;
      drain_cnt <= '0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (!last_b) b <= b + BW'(1);
        end
        ST_DRAIN: begin
          if (drain_last) begin
            drain_cnt <= '0;
            b         <= '0;
            if (!last_stage) s <= s + LOG_N'(1);
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_DONE: s <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_vld[i] <= 1'b0;
        dl_a1[i]  <= '0;
        dl_a2[i]  <= '0;
      end
    end else if (!stall) begin
      dl_vld[0] <= rd_en;
      dl_a1[0]  <= gen_a1;
      dl_a2[0]  <= gen_a2;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_a1[i]  <= dl_a1[i-1];
        dl_a2[i]  <= dl_a2[i-1];
      end
    end
  end

  assign wr_en = dl_vld[PIPE_LAT-1] & ~stall;

  // Addresses are only meaningful alongside their enable; holding them at
  // zero otherwise keeps the idle interface quiet.
  assign stage     = s;
  assign rd_addr_1 = rd_en ? gen_a1 : '0;
  assign rd_addr_2 = rd_en ? gen_a2 : '0;
  assign tw_addr   = rd_en ? gen_tw : '0;
  assign wr_addr_1 = wr_en ? dl_a1[PIPE_LAT-1] : '0;
  assign wr_addr_2 = wr_en ? dl_a2[PIPE_LAT-1] : '0;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
module tb_ntt_stage_scheduler;

  logic clk;
  logic rst, start, stall;

  logic       busy0, done0, rd0, wr0;
  logic [2:0] st0, ra1_0, ra2_0, wa1_0, wa2_0;
  logic [1:0] tw0;

  logic       busy1, done1, rd1, wr1;
  logic [0:0] st1, ra1_1, ra2_1, wa1_1, wa2_1, tw1;

  logic [31:0] o_busy, o_done, o_rd, o_wr, o_stage, o_ra1, o_ra2, o_tw, o_wa1, o_wa2;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ntt_stage_scheduler #(.WIDTH(18), .LOG_N(3), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy0), .done(done0), .stage(st0),
    .rd_en(rd0), .rd_addr_1(ra1_0), .rd_addr_2(ra2_0), .tw_addr(tw0),
    .wr_en(wr0), .wr_addr_1(wa1_0), .wr_addr_2(wa2_0)
  );

  ntt_stage_scheduler #(.WIDTH(18), .LOG_N(1), .PIPE_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy1), .done(done1), .stage(st1),
    .rd_en(rd1), .rd_addr_1(ra1_1), .rd_addr_2(ra2_1), .tw_addr(tw1),
    .wr_en(wr1), .wr_addr_1(wa1_1), .wr_addr_2(wa2_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic grab(input int sel);
    if (sel == 0) begin
      o_busy = 32'(busy0); o_done = 32'(done0); o_rd = 32'(rd0); o_wr = 32'(wr0);
      o_stage = 32'(st0); o_ra1 = 32'(ra1_0); o_ra2 = 32'(ra2_0); o_tw = 32'(tw0);
      o_wa1 = 32'(wa1_0); o_wa2 = 32'(wa2_0);
    end else begin
      o_busy = 32'(busy1); o_done = 32'(done1); o_rd = 32'(rd1); o_wr = 32'(wr1);
      o_stage = 32'(st1); o_ra1 = 32'(ra1_1); o_ra2 = 32'(ra2_1); o_tw = 32'(tw1);
      o_wa1 = 32'(wa1_1); o_wa2 = 32'(wa2_1);
    end
  endtask

  // Butterfly i of stage st in natural DIT order: groups of 2*half points,
  // pairs (base+k, base+k+half), twiddle k scaled by N/(2*half).
  function automatic void pair(input int ln, input int st, input int i,
                               output int a1, output int a2, output int tw);
    int half, g, k;
    half = 1 << st;
    g    = i / half;
    k    = i % half;
    a1   = g * 2 * half + k;
    a2   = a1 + half;
    tw   = k * ((1 << ln) / (2 * half));
  endfunction

  task automatic check_idle(input string pfx);
    chk({pfx, "_busy"},  o_busy,  0);
    chk({pfx, "_done"},  o_done,  0);
    chk({pfx, "_rd_en"}, o_rd,    0);
    chk({pfx, "_wr_en"}, o_wr,    0);
    chk({pfx, "_stage"}, o_stage, 0);
    chk({pfx, "_ra1"},   o_ra1,   0);
    chk({pfx, "_ra2"},   o_ra2,   0);
    chk({pfx, "_tw"},    o_tw,    0);
    chk({pfx, "_wa1"},   o_wa1,   0);
    chk({pfx, "_wa2"},   o_wa2,   0);
  endtask

  task automatic do_reset(input int sel);
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    grab(sel);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One transform. The model counts non-stalled cycles (a) since the start
  // cycle and derives every expected output from that count alone.
  task automatic run(input int sel, input int slo, input int shi, input int pct,
                     input int rst_at, input bit rstart, input int exp_done);
    int ln, p, h, per, tot, a, c, done_cyc, rel, r2, a1, a2, tw;
    bit aborted, fin, stl, busy_e, done_e, rd_e, wr_e;
    ln = (sel != 0) ? 1 : 3;
    p  = (sel != 0) ? 1 : 2;
    h  = 1 << (ln - 1);
    per = h + p;
    tot = ln * per;
    a = 0; c = 0; done_cyc = -1; aborted = 0; fin = 0;
    while (!fin && c < 3000) begin
      @(posedge clk);
      #1;
      stl = (c != 0) && ((c >= slo && c <= shi) ||
                         (a <= tot && int'($urandom_range(99)) < pct));
      stall = stl;
      rst   = (c == rst_at);
      start = (c == 0) || (rstart && !aborted && a >= 1 && a <= tot + 1 &&
                           (a == tot + 1 || $urandom_range(1) == 1));
      @(negedge clk);
      grab(sel);
      if (o_done === 32'd1 && done_cyc < 0) done_cyc = c;
      if (aborted || a == 0 || a >= tot + 2) begin
        check_idle("idle");
      end else begin
        busy_e = (a <= tot);
        done_e = (a == tot + 1);
        rel    = a - 1;
        r2     = a - 1 - p;
        rd_e   = !stl && busy_e && (rel % per) < h;
        wr_e   = !stl && r2 >= 0 && r2 < tot && (r2 % per) < h;
        chk("busy",  o_busy, 32'(busy_e));
        chk("done",  o_done, 32'(done_e));
        chk("rd_en", o_rd,   32'(rd_e));
        chk("wr_en", o_wr,   32'(wr_e));
        if (busy_e) chk("stage", o_stage, rel / per);
        if (rd_e) begin
          pair(ln, rel / per, rel % per, a1, a2, tw);
          chk("rd_addr_1", o_ra1, a1);
          chk("rd_addr_2", o_ra2, a2);
          chk("tw_addr",   o_tw,  tw);
        end
        if (wr_e) begin
          pair(ln, r2 / per, r2 % per, a1, a2, tw);
          chk("wr_addr_1", o_wa1, a1);
          chk("wr_addr_2", o_wa2, a2);
        end
      end
      if (c == rst_at) aborted = 1;
      if (!stl) a++;
      c++;
      fin = aborted ? (c > rst_at + 4) : (a > tot + 3);
    end
    chk("run_timeout", 32'(fin), 1);
    start = 1'b0; stall = 1'b0; rst = 1'b0;
    if (exp_done != -2) chk("done_cycle", done_cyc, exp_done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;

    do_reset(0);
    run(0, -1, -1, 0, -1, 0, 19);      // N=8 plain: done at cycle 19

    do_reset(0);
    run(0, 2, 4, 0, -1, 0, 22);        // stall cycles 2-4: shifted by 3

    do_reset(0);
    run(0, -1, -1, 0, 9, 0, -1);       // abort at cycle 9: no done
    run(0, -1, -1, 0, -1, 0, 19);      // fresh start replays from stage 0

    do_reset(0);
    run(0, -1, -1, 0, -1, 1, 19);      // start while busy / in DONE ignored

    do_reset(1);
    run(1, -1, -1, 0, -1, 0, 3);       // LOG_N=1, PIPE_LAT=1

    for (int r = 0; r < 3; r++) begin
      do_reset(0);
      run(0, -1, -1, 25, -1, 1, -2);
    end
    for (int r = 0; r < 2; r++) begin
      do_reset(1);
      run(1, -1, -1, 30, -1, 1, -2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
